sobel_grad_stream: RTL

Streaming 3x3 Sobel gradient engine with valid/ready flow control, per-line border suppression and an optional L1 magnitude output. It consumes one vertical 3-pixel column per accepted beat from the line-buffer front end and emits horizontal/vertical gradients to the SIFT orientation and keypoint stages. It generalises the free-running, enable-only Sobel core with:

- parametrised line width,
- backpressure,
- line framing,
- a selectable magnitude mode.

---
 rtl/sobel_grad_stream_if.sv | 30 +++
 rtl/sobel_grad_stream.sv | 93 +++++++++
 2 files changed

// File: rtl/sobel_grad_stream_if.sv
// Column-in / gradient-out stream bundle for sobel_grad_stream.
// master = column producer and result consumer, slave = gradient engine.
interface sobel_grad_stream_if #(
  parameter int dataW = 8
);
  localparam int outW = dataW + 3;

  logic                   in_valid;
  logic                   in_ready;
  logic [3*dataW-1:0]     in_col;
  logic                   in_sol;
  logic                   in_eol;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sol;
  logic                   out_eol;
  logic signed [outW-1:0] XEdge;
  logic signed [outW-1:0] YEdge;
  logic [outW-1:0]        Mag;

  modport master (
    output in_valid, in_col, in_sol, in_eol, out_ready,
    input  in_ready, out_valid, out_sol, out_eol, XEdge, YEdge, Mag
  );

  modport slave (
    input  in_valid, in_col, in_sol, in_eol, out_ready,
    output in_ready, out_valid, out_sol, out_eol, XEdge, YEdge, Mag
  );
endinterface

// File: rtl/sobel_grad_stream.sv
// Streaming 3x3 Sobel gradient engine: one column per beat, single output
// register with valid/ready, line framing and optional L1 magnitude.
module sobel_grad_stream #(
  parameter int dataW  = 8,
  parameter int imgW   = 640,
  parameter int MAG_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  sobel_grad_stream_if.slave s
);
  localparam int outW = dataW + 3;
  localparam int CW   = (imgW > 2) ? $clog2(imgW) : 2;

  logic [dataW-1:0]       p0, p1, p2;
  logic [dataW+1:0]       s_cur, s1, s2;
  logic signed [dataW:0]  d_cur, d1, d2;
  logic signed [outW-1:0] xe, ye;
  logic [outW-1:0]        ax, ay, mag_nxt;
  logic [CW-1:0]          cnt, idx;
  logic                   acc, produce;

  logic                   out_valid_q, out_sol_q, out_eol_q;
  logic signed [outW-1:0] xedge_q, yedge_q;
  logic [outW-1:0]        mag_q;

  assign p0 = s.in_col[0       +: dataW];
  assign p1 = s.in_col[dataW   +: dataW];
  assign p2 = s.in_col[2*dataW +: dataW];

  assign s.in_ready = !out_valid_q || s.out_ready;
  assign acc        = s.in_valid && s.in_ready;
  // A start-of-line column is always index 0, whatever the counter holds.
  assign idx        = s.in_sol ? '0 : cnt;
  assign produce    = acc && (idx >= CW'(2));

  always_comb begin
    s_cur   = (dataW+2)'(p0) + ((dataW+2)'(p1) << 1) + (dataW+2)'(p2);
    d_cur   = $signed({1'b0, p0}) - $signed({1'b0, p2});
    ye      = $signed(outW'(s_cur)) - $signed(outW'(s2));
    xe      = outW'(d_cur) + (outW'(d1) <<< 1) + outW'(d2);
    ax      = xe[outW-1] ? -xe : xe;
    ay      = ye[outW-1] ? -ye : ye;
    mag_nxt = (MAG_EN != 0) ? (ax + ay) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      d1          <= '0;
      d2          <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      xedge_q     <= '0;
      yedge_q     <= '0;
      mag_q       <= '0;
    end else begin
      if (acc) begin
        s1 <= s_cur;
        s2 <= s1;
        d1 <= d_cur;
        d2 <= d1;
        if (s.in_sol)
          cnt <= CW'(1);
        else if (cnt == CW'(imgW - 1))
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
      end
      // A new result replaces a draining one in the same cycle.
      if (produce) begin
        out_valid_q <= 1'b1;
        xedge_q     <= xe;
        yedge_q     <= ye;
        mag_q       <= mag_nxt;
        out_sol_q   <= (idx == CW'(2));
        out_eol_q   <= s.in_eol;
      end else if (s.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_sol   = out_sol_q;
  assign s.out_eol   = out_eol_q;
  assign s.XEdge     = xedge_q;
  assign s.YEdge     = yedge_q;
  assign s.Mag       = mag_q;
endmodule
